// File: rtl/core_scheduler_if.sv
// Scheduler bundle: dispatcher start/done, fetch/decode/LSU status in,
// core_state and current_pc out to the per-thread datapath.
interface core_scheduler_if #(
   parameter int THREADS_PER_BLOCK     = 4,
   parameter int PROGRAM_MEM_ADDR_BITS = 8
);
   logic                                           start;
   logic [THREADS_PER_BLOCK-1:0]                   thread_enable;
   logic [2:0]                                     fetcher_state;
   logic                                           decoded_mem_read_enable;
   logic                                           decoded_mem_write_enable;
   logic                                           decoded_ret;
   logic [2*THREADS_PER_BLOCK-1:0]                 lsu_state;
   logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc;
   logic [2:0]                                     core_state;
   logic [PROGRAM_MEM_ADDR_BITS-1:0]               current_pc;
   logic                                           done;

   modport master (
      output start, thread_enable, fetcher_state,
      output decoded_mem_read_enable, decoded_mem_write_enable,
      output decoded_ret, lsu_state, next_pc,
      input  core_state, current_pc, done
   );

   modport slave (
      input  start, thread_enable, fetcher_state,
      input  decoded_mem_read_enable, decoded_mem_write_enable,
      input  decoded_ret, lsu_state, next_pc,
      output core_state, current_pc, done
   );
endinterface

// File: rtl/core_scheduler.sv
// Per-core FSM: FETCH..UPDATE per instruction, owns current_pc, done on RET.
// Ports: clk, reset (async high), bus (core_scheduler_if.slave).
module core_scheduler #(
   parameter int THREADS_PER_BLOCK     = 4,
   parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
   input logic              clk,
   input logic              reset,
   core_scheduler_if.slave  bus
);
   localparam int T = THREADS_PER_BLOCK;
   localparam int A = PROGRAM_MEM_ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_FETCH   = 3'b001,
      S_DECODE  = 3'b010,
      S_REQUEST = 3'b011,
      S_WAIT    = 3'b100,
      S_EXECUTE = 3'b101,
      S_UPDATE  = 3'b110,
      S_DONE    = 3'b111
   } state_e;

   state_e         state_q, state_d;
   logic [A-1:0]   pc_q, pc_d;
   logic           mem_busy;
   logic           unused_inputs;

   // Memory flags and the lower next_pc lanes are not needed:
   // lanes are assumed converged, so the last lane supplies the PC.
   assign unused_inputs = ^{bus.decoded_mem_read_enable,
                            bus.decoded_mem_write_enable,
                            bus.next_pc[A*(T-1)-1:0]};

   // An enabled lane in REQUESTING or WAITING holds the core in WAIT.
   always_comb begin
      mem_busy = 1'b0;
      for (int i = 0; i < T; i++) begin
         if (bus.thread_enable[i] &&
             (bus.lsu_state[2*i +: 2] == 2'b01 ||
              bus.lsu_state[2*i +: 2] == 2'b10))
            mem_busy = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_IDLE:    if (bus.start) state_d = S_FETCH;
         S_FETCH:   if (bus.fetcher_state == 3'b010) state_d = S_DECODE;
         S_DECODE:  state_d = S_REQUEST;
         S_REQUEST: state_d = S_WAIT;
         S_WAIT:    if (!mem_busy) state_d = S_EXECUTE;
         S_EXECUTE: state_d = S_UPDATE;
         S_UPDATE: begin
            if (bus.decoded_ret) begin
               state_d = S_DONE;
            end else begin
               pc_d    = bus.next_pc[A*(T-1) +: A];
               state_d = S_FETCH;
            end
         end
         S_DONE:    if (!bus.start) state_d = S_IDLE;
      endcase
   end

   // done is decoded from the state register, so it stays registered.
   always_comb begin
      bus.core_state = state_q;
      bus.current_pc = pc_q;
      bus.done       = (state_q == S_DONE);
   end
endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: directed cases plus random
// instructions checked against a per-instruction timing model.
module tb_core_scheduler;
   localparam int T = 4;
   localparam int A = 8;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1,
      ST_DECODE = 3'd2, ST_REQUEST = 3'd3, ST_WAIT = 3'd4,
      ST_EXECUTE = 3'd5, ST_UPDATE = 3'd6, ST_DONE = 3'd7;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [A-1:0] exp_pc;

   core_scheduler_if #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) bus ();

   core_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(A)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [2:0] es);
      @(posedge clk);
      #1;
      check("state", 32'(bus.core_state), 32'(es));
      check("pc", 32'(bus.current_pc), 32'(exp_pc));
      check("done", 32'(bus.done), 32'(es == ST_DONE));
   endtask

   // Randomize everything the current state must ignore.
   task automatic noise();
      bus.start                    = 1'($urandom);
      bus.fetcher_state            = 3'($urandom);
      bus.decoded_mem_read_enable  = 1'($urandom);
      bus.decoded_mem_write_enable = 1'($urandom);
      bus.decoded_ret              = 1'($urandom);
      bus.lsu_state                = 8'($urandom);
      bus.next_pc                  = 32'($urandom);
   endtask

   // Disabled lanes always look pending; they must not hold WAIT.
   task automatic set_lsu(input logic [T-1:0] mask, input bit busy);
      logic [2*T-1:0] v;
      int bl;
      v  = '0;
      bl = 0;
      if (busy)
         do bl = $urandom_range(0, T-1); while (!mask[bl]);
      for (int i = 0; i < T; i++) begin
         if (!mask[i])
            v[2*i +: 2] = $urandom_range(0, 1) ? 2'b01 : 2'b10;
         else if (busy && i == bl)
            v[2*i +: 2] = $urandom_range(0, 1) ? 2'b01 : 2'b10;
         else if (busy)
            v[2*i +: 2] = 2'($urandom);
         else
            v[2*i +: 2] = $urandom_range(0, 1) ? 2'b00 : 2'b11;
      end
      bus.lsu_state = v;
   endtask

   // One instruction starting with the core in FETCH; ends in FETCH.
   // Expected: FETCH f+1 cycles, DECODE, REQUEST, WAIT m+1, EXECUTE,
   // UPDATE, then FETCH with new PC or DONE/IDLE on RET.
   task automatic run_instr(input int f, input int m,
                            input logic [T-1:0] mask, input bit ret,
                            input logic [A-1:0] npc, input int hold,
                            input bit aa_lanes);
      bus.thread_enable = mask;
      for (int i = 0; i < f; i++) begin
         noise();
         do bus.fetcher_state = 3'($urandom);
         while (bus.fetcher_state == 3'b010);
         step(ST_FETCH);
      end
      noise();
      bus.fetcher_state = 3'b010;
      step(ST_DECODE);
      noise();
      step(ST_REQUEST);
      noise();
      step(ST_WAIT);
      for (int j = 0; j < m; j++) begin
         noise();
         set_lsu(mask, 1'b1);
         step(ST_WAIT);
      end
      noise();
      set_lsu(mask, 1'b0);
      step(ST_EXECUTE);
      noise();
      step(ST_UPDATE);
      noise();
      bus.decoded_ret = ret;
      if (aa_lanes) bus.next_pc = {npc, 8'hAA, 8'hAA, 8'hAA};
      else          bus.next_pc[A*(T-1) +: A] = npc;
      if (!ret) begin
         exp_pc = npc;
         step(ST_FETCH);
      end else begin
         step(ST_DONE);
         for (int k = 0; k < hold; k++) begin
            noise();
            bus.start = 1'b1;
            step(ST_DONE);
         end
         noise();
         bus.start = 1'b0;
         step(ST_IDLE);
         for (int k = 0; k < $urandom_range(0, 2); k++) begin
            noise();
            bus.start = 1'b0;
            step(ST_IDLE);
         end
         noise();
         bus.start = 1'b1;
         step(ST_FETCH);
      end
   endtask

   initial begin
      reset  = 1'b1;
      exp_pc = '0;
      bus.start = 1'b0;
      bus.thread_enable = '1;
      bus.fetcher_state = '0;
      bus.decoded_mem_read_enable = 1'b0;
      bus.decoded_mem_write_enable = 1'b0;
      bus.decoded_ret = 1'b0;
      bus.lsu_state = '0;
      bus.next_pc = '0;
      @(posedge clk);
      #1;
      check("rst_state", 32'(bus.core_state), 32'(ST_IDLE));
      check("rst_pc", 32'(bus.current_pc), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      #2 reset = 1'b0;
      step(ST_IDLE);
      bus.start = 1'b1;
      step(ST_FETCH);

      // Minimum latency, then FETCH stall, then memory stalls.
      run_instr(0, 0, 4'b1111, 1'b0, 8'h01, 0, 1'b0);
      run_instr(4, 0, 4'b1111, 1'b0, 8'h22, 0, 1'b0);
      run_instr(0, 5, 4'b1111, 1'b0, 8'h33, 0, 1'b0);
      run_instr(1, 0, 4'b1011, 1'b0, 8'h44, 0, 1'b0);
      run_instr(0, 0, 4'b0000, 1'b0, 8'h55, 0, 1'b0);

      // Async reset in the middle of a WAIT stall.
      noise();
      bus.thread_enable = 4'b1111;
      bus.fetcher_state = 3'b010;
      step(ST_DECODE);
      step(ST_REQUEST);
      set_lsu(4'b1111, 1'b1);
      step(ST_WAIT);
      #3 reset = 1'b1;
      #1;
      check("arst_state", 32'(bus.core_state), 32'(ST_IDLE));
      check("arst_pc", 32'(bus.current_pc), 32'h0);
      check("arst_done", 32'(bus.done), 32'h0);
      exp_pc = '0;
      #2 reset = 1'b0;
      bus.start = 1'b0;
      step(ST_IDLE);
      step(ST_IDLE);
      bus.start = 1'b1;
      step(ST_FETCH);

      // RET with PC 0C held through DONE.
      run_instr(0, 0, 4'b1111, 1'b0, 8'h0C, 0, 1'b0);
      run_instr(0, 0, 4'b1111, 1'b1, 8'h0D, 3, 1'b0);

      // PC wrap with decoy lanes.
      run_instr(0, 0, 4'b1111, 1'b0, 8'hFF, 0, 1'b1);
      run_instr(0, 0, 4'b1111, 1'b0, 8'h00, 0, 1'b1);

      for (int n = 0; n < 80; n++) begin
         logic [T-1:0] mask;
         mask = 4'($urandom);
         run_instr($urandom_range(0, 3),
                   (mask == 0) ? 0 : $urandom_range(0, 4),
                   mask, ($urandom_range(0, 5) == 0),
                   8'($urandom), $urandom_range(0, 3), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
